// File: rtl/gbt_rx_link_monitor_if.sv
// gbt_rx_link_monitor_if: clock/reset bundle for the frame clock domain
interface gbt_rx_link_monitor_if;
   logic clk;
   logic reset;
   modport sink (input clk, input reset);
endinterface

// File: rtl/gbt_rx_link_monitor.sv
// gbt_rx_link_monitor: GBT RX sequence check, lock hysteresis, error count, payload forwarding
module gbt_rx_link_monitor #(
   parameter int DATA_W     = 80,
   parameter int SEQ_W      = 8,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_ERR = 4,
   parameter int ERRCNT_W   = 16
) (
   gbt_rx_link_monitor_if.sink         ClkRs_ix,
   input  logic                        RxReady_i,
   input  logic                        RxValid_i,
   input  logic [DATA_W-1:0]           RxData_ib,
   input  logic                        ClrErr_i,
   output logic [DATA_W-SEQ_W-1:0]     Data_ob,
   output logic                        DataValid_o,
   output logic                        LinkUp_o,
   output logic [1:0]                  State_ob,
   output logic                        SeqErr_o,
   output logic [ERRCNT_W-1:0]         ErrCnt_ob
);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_ERR + 1);
   localparam logic [1:0] DOWN = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2;
   logic [1:0] state_nx;
   logic [SEQ_W-1:0] seq, exp_seq;
   logic primed;
   logic [GW-1:0] good_cnt;
   logic [BW-1:0] bad_cnt;
   logic frame, hit, fwd, err_ev, lock_ev, unlock_ev;
   assign seq = RxData_ib[DATA_W-1 -: SEQ_W];
   assign frame = RxReady_i && RxValid_i && State_ob != DOWN;
   // the first frame after DOWN only primes exp_seq, so it can never be good
   assign hit = primed && seq == exp_seq;
   assign fwd = frame && State_ob == LOCKED && hit;
   assign err_ev = frame && State_ob == LOCKED && !hit;
   assign lock_ev = frame && State_ob == ACQUIRE && hit && good_cnt == GW'(LOCK_CNT - 1);
   assign unlock_ev = err_ev && bad_cnt == BW'(UNLOCK_ERR - 1);
   assign state_nx = !RxReady_i ? DOWN : State_ob == DOWN ? ACQUIRE :
                     lock_ev ? LOCKED : unlock_ev ? ACQUIRE : State_ob;
   always_ff @(posedge ClkRs_ix.clk) begin
      if (!ClkRs_ix.reset) begin
         State_ob    <= DOWN;
         LinkUp_o    <= 1'b0;
         DataValid_o <= 1'b0;
         SeqErr_o    <= 1'b0;
         Data_ob     <= '0;
         ErrCnt_ob   <= '0;
         exp_seq     <= '0;
         primed      <= 1'b0;
         good_cnt    <= '0;
         bad_cnt     <= '0;
      end else begin
         State_ob    <= state_nx;
         LinkUp_o    <= state_nx == LOCKED;
         DataValid_o <= fwd;
         SeqErr_o    <= err_ev;
         if (fwd) Data_ob <= RxData_ib[DATA_W-SEQ_W-1:0];
         ErrCnt_ob <= ClrErr_i ? ERRCNT_W'(err_ev) :
                      (err_ev && !(&ErrCnt_ob)) ? ErrCnt_ob + 1'b1 : ErrCnt_ob;
         if (!RxReady_i || State_ob == DOWN) begin
            exp_seq  <= '0;
            primed   <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
         end else if (frame) begin
            exp_seq  <= seq + 1'b1;
            primed   <= 1'b1;
            good_cnt <= (State_ob == ACQUIRE && hit && !lock_ev) ? good_cnt + 1'b1 : '0;
            bad_cnt  <= (State_ob == LOCKED && !hit && !unlock_ev) ? bad_cnt + 1'b1 : '0;
         end
      end
   end
endmodule

// File: tb/tb_gbt_rx_link_monitor.sv
// tb_gbt_rx_link_monitor: directed frames with a payload scoreboard checked on DataValid_o
module tb_gbt_rx_link_monitor;
   localparam int DATA_W = 80, SEQ_W = 8, ERRCNT_W = 4;
   gbt_rx_link_monitor_if cr ();
   logic RxReady_i = 0, RxValid_i = 0, ClrErr_i = 0;
   logic [DATA_W-1:0] RxData_ib = '0;
   logic [DATA_W-SEQ_W-1:0] Data_ob;
   logic DataValid_o, LinkUp_o, SeqErr_o;
   logic [1:0] State_ob;
   logic [ERRCNT_W-1:0] ErrCnt_ob;
   logic [DATA_W-SEQ_W-1:0] q[$];
   int n_chk = 0, n_fail = 0, seen_err = 0, exp_err = 0;
   int unsigned pay_id = 1;
   logic [7:0] nxt, s;

   gbt_rx_link_monitor #(.DATA_W(DATA_W), .SEQ_W(SEQ_W), .LOCK_CNT(16), .UNLOCK_ERR(4),
                         .ERRCNT_W(ERRCNT_W)) dut (
      .ClkRs_ix(cr), .RxReady_i(RxReady_i), .RxValid_i(RxValid_i), .RxData_ib(RxData_ib),
      .ClrErr_i(ClrErr_i), .Data_ob(Data_ob), .DataValid_o(DataValid_o), .LinkUp_o(LinkUp_o),
      .State_ob(State_ob), .SeqErr_o(SeqErr_o), .ErrCnt_ob(ErrCnt_ob));

   initial begin
      cr.clk = 0;
      forever #5 cr.clk = ~cr.clk;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   always @(negedge cr.clk) begin
      if (SeqErr_o === 1'b1) seen_err++;
      if (DataValid_o === 1'b1) begin
         if (q.size() == 0) check("unexpected_datavalid", 128'(Data_ob), 128'h0 - 1);
         else check("payload", 128'(Data_ob), 128'(q.pop_front()));
      end
   end

   task automatic idle(input int n);
      RxValid_i = 0;
      repeat (n) @(posedge cr.clk);
      #1;
   endtask

   task automatic frame(input logic [7:0] sq, input bit fwd, input bit err);
      logic [DATA_W-SEQ_W-1:0] pay;
      pay = {pay_id, sq, ~pay_id};
      pay_id++;
      RxValid_i = 1;
      RxData_ib = {sq, pay};
      if (fwd) q.push_back(pay);
      if (err) exp_err++;
      @(posedge cr.clk);
      #1;
      RxValid_i = 0;
   endtask

   initial begin
      cr.reset = 0;
      idle(3);
      check("rst_state", 128'(State_ob), 0);
      check("rst_linkup", 128'(LinkUp_o), 0);
      check("rst_dvalid", 128'(DataValid_o), 0);
      check("rst_seqerr", 128'(SeqErr_o), 0);
      check("rst_errcnt", 128'(ErrCnt_ob), 0);
      check("rst_data", 128'(Data_ob), 0);
      cr.reset = 1;
      // lock acquisition
      RxReady_i = 1;
      idle(1);
      check("acquire_entry", 128'(State_ob), 1);
      for (int i = 0; i <= 16; i++) begin
         frame(8'(i), 0, 0);
         if (i == 15) check("not_yet_locked", 128'(LinkUp_o), 0);
      end
      check("lock_linkup", 128'(LinkUp_o), 1);
      check("lock_state", 128'(State_ob), 2);
      frame(8'd17, 1, 0);
      check("lock_errcnt", 128'(ErrCnt_ob), 0);
      // wrap with random gaps
      for (int i = 18; i <= 249; i++) frame(8'(i), 1, 0);
      for (int i = 0; i < 12; i++) begin
         idle($urandom_range(0, 3));
         frame(8'(250 + i), 1, 0);
      end
      idle(2);
      check("wrap_no_seqerr", 128'(seen_err), 0);
      check("wrap_linkup", 128'(LinkUp_o), 1);
      check("wrap_all_fwd", 128'(q.size()), 0);
      // single error and resync
      for (int i = 6; i <= 11; i++) frame(8'(i), 1, 0);
      frame(8'd40, 0, 1);
      frame(8'd41, 1, 0);
      frame(8'd42, 1, 0);
      idle(1);
      check("single_errcnt", 128'(ErrCnt_ob), 1);
      check("single_seqerr", 128'(seen_err), 128'(exp_err));
      check("single_linkup", 128'(LinkUp_o), 1);
      // clear alone, then lock loss
      ClrErr_i = 1;
      idle(1);
      ClrErr_i = 0;
      check("clr_alone", 128'(ErrCnt_ob), 0);
      frame(8'd100, 0, 1);
      frame(8'd150, 0, 1);
      frame(8'd200, 0, 1);
      check("three_err_still_locked", 128'(State_ob), 2);
      frame(8'd20, 0, 1);
      check("unlock_state", 128'(State_ob), 1);
      check("unlock_linkup", 128'(LinkUp_o), 0);
      idle(1);
      check("unlock_errcnt", 128'(ErrCnt_ob), 4);
      check("unlock_seqerr", 128'(seen_err), 128'(exp_err));
      for (int i = 21; i <= 36; i++) begin
         frame(8'(i), 0, 0);
         if (i == 35) check("relock_pending", 128'(State_ob), 1);
      end
      check("relock_state", 128'(State_ob), 2);
      frame(8'd37, 1, 0);
      nxt = 8'd38;
      // saturation: each error followed by a good frame keeps the link locked
      for (int k = 0; k < 12; k++) begin
         s = nxt + 8'd50;
         frame(s, 0, 1);
         frame(s + 8'd1, 1, 0);
         nxt = s + 8'd2;
         if (k == 10) check("sat_reach", 128'(ErrCnt_ob), 15);
      end
      check("sat_hold", 128'(ErrCnt_ob), 15);
      check("sat_locked", 128'(State_ob), 2);
      ClrErr_i = 1;
      s = nxt + 8'd50;
      frame(s, 0, 1);
      ClrErr_i = 0;
      check("clr_with_err", 128'(ErrCnt_ob), 1);
      frame(s + 8'd1, 1, 0);
      // ready drop while locked
      RxReady_i = 0;
      idle(1);
      check("drop_state", 128'(State_ob), 0);
      check("drop_linkup", 128'(LinkUp_o), 0);
      check("drop_errcnt", 128'(ErrCnt_ob), 1);
      RxReady_i = 1;
      idle(1);
      check("drop_reacquire", 128'(State_ob), 1);
      for (int i = 0; i <= 16; i++) frame(8'(i), 0, 0);
      frame(8'd17, 1, 0);
      check("relock2_linkup", 128'(LinkUp_o), 1);
      // reset mid-lock, with a good frame offered in the reset cycle
      cr.reset = 0;
      frame(8'd18, 0, 0);
      check("mid_rst_state", 128'(State_ob), 0);
      check("mid_rst_linkup", 128'(LinkUp_o), 0);
      check("mid_rst_errcnt", 128'(ErrCnt_ob), 0);
      check("mid_rst_data", 128'(Data_ob), 0);
      check("mid_rst_dvalid", 128'(DataValid_o), 0);
      check("mid_rst_seqerr", 128'(SeqErr_o), 0);
      cr.reset = 1;
      idle(3);
      check("final_queue_empty", 128'(q.size()), 0);
      check("final_seqerr_count", 128'(seen_err), 128'(exp_err));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
